// File: rtl/alu_issue.sv
// alu_issue: decodes one RV32I integer/branch instruction, drives the ALU handshake
// and holds the result for writeback, with a watchdog on the ALU response.
module alu_issue #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic            alu_sub,
  output logic            alu_sign,
  output logic            alu_is_arch,
  output logic            alu_in_valid,
  input  logic            alu_out_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_branch,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal,
  output logic            timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [TW-1:0] wd;
  logic is_br;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [3:0] d_ctrl;
  logic [XLEN-1:0] d_a, d_b;
  logic d_sub, d_sign, d_arch, d_legal, d_br;
  logic unused_bits;
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign unused_bits = ^inst[24:15];
  assign inst_ready = state == IDLE;
  always_comb begin
    d_ctrl = {1'b0, f3};
    d_a = rs1_data;
    d_b = imm;
    d_sub = 1'b0;
    d_sign = 1'b0;
    d_arch = 1'b0;
    d_legal = 1'b0;
    d_br = 1'b0;
    case (op)
      7'b0010011: begin
        d_legal = f3 == 3'b001 ? f7 == 7'd0 : f3 == 3'b101 ? (f7 == 7'd0 || f7 == 7'h20) : 1'b1;
        d_sub = f3[2:1] == 2'b01;
        d_sign = f3 == 3'b010;
        d_arch = f3 == 3'b101 && inst[30];
      end
      7'b0110011: begin
        d_b = rs2_data;
        d_legal = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        d_sub = f3[2:1] == 2'b01 || (f3 == 3'b000 && f7 == 7'h20);
        d_sign = f3 == 3'b010;
        d_arch = f3 == 3'b101 && f7 == 7'h20;
      end
      7'b0110111: begin
        d_ctrl = 4'd0;
        d_a = '0;
        d_legal = 1'b1;
      end
      7'b0010111: begin
        d_ctrl = 4'd0;
        d_a = pc;
        d_legal = 1'b1;
      end
      7'b1100011: begin
        d_ctrl = {1'b1, f3};
        d_b = rs2_data;
        d_sub = 1'b1;
        d_sign = f3[2] & ~f3[1];
        d_legal = f3[2:1] != 2'b01;
        d_br = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      is_br <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      alu_sub <= 1'b0;
      alu_sign <= 1'b0;
      alu_is_arch <= 1'b0;
      alu_in_valid <= 1'b0;
      wb_valid <= 1'b0;
      wb_result <= '0;
      wb_rd <= '0;
      wb_we <= 1'b0;
      br_taken <= 1'b0;
      br_target <= '0;
      illegal <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (inst_valid) begin
          alu_a <= d_a;
          alu_b <= d_b;
          alu_ctrl <= d_ctrl;
          alu_sub <= d_sub;
          alu_sign <= d_sign;
          alu_is_arch <= d_arch;
          is_br <= d_br;
          wb_rd <= inst[11:7];
          br_target <= pc + imm;
          wb_result <= '0;
          wb_we <= 1'b0;
          illegal <= ~d_legal;
          alu_in_valid <= d_legal;
          wb_valid <= ~d_legal;
          state <= d_legal ? ISSUE : DONE;
        end
        ISSUE: begin
          alu_in_valid <= 1'b0;
          wd <= TW'(TIMEOUT);
          state <= WAIT;
        end
        WAIT: if (alu_out_valid) begin
          wb_result <= alu_result;
          br_taken <= is_br & alu_branch;
          wb_we <= ~is_br && wb_rd != 5'd0;
          wb_valid <= 1'b1;
          state <= DONE;
        end else if (wd == TW'(1)) begin
          wd <= '0;
          timeout_err <= 1'b1;
          wb_we <= 1'b0;
          wb_valid <= 1'b1;
          state <= DONE;
        end else begin
          wd <= wd - 1'b1;
        end
        DONE: if (wb_ready) begin
          wb_valid <= 1'b0;
          br_taken <= 1'b0;
          illegal <= 1'b0;
          timeout_err <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed scoreboard bench for alu_issue with a scripted 1-cycle ALU.
module tb_alu_issue;
  localparam int TO = 3;
  logic clock = 1'b0, reset = 1'b1;
  logic inst_valid = 1'b0, inst_ready;
  logic [31:0] inst = '0, pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic [31:0] alu_a, alu_b;
  logic [3:0] alu_ctrl;
  logic alu_sub, alu_sign, alu_is_arch, alu_in_valid;
  logic alu_out_valid = 1'b0, alu_branch = 1'b0;
  logic [31:0] alu_result = '0;
  logic wb_valid, wb_ready = 1'b0;
  logic [31:0] wb_result;
  logic [4:0] wb_rd;
  logic wb_we, br_taken, illegal, timeout_err;
  logic [31:0] br_target;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] res;
    logic [4:0] rd;
    logic we, br;
    logic [31:0] tgt;
    logic ill, to;
  } exp_t;
  exp_t q[$];
  alu_issue #(.XLEN(32), .TIMEOUT(TO), .TW(4)) dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_sub(alu_sub),
    .alu_sign(alu_sign), .alu_is_arch(alu_is_arch), .alu_in_valid(alu_in_valid),
    .alu_out_valid(alu_out_valid), .alu_result(alu_result), .alu_branch(alu_branch),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_we(wb_we), .br_taken(br_taken), .br_target(br_target), .illegal(illegal),
    .timeout_err(timeout_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] res, input logic [4:0] rd, input logic we, br,
                              input logic [31:0] tgt, input logic ill, to);
    exp_t e;
    e.res = res; e.rd = rd; e.we = we; e.br = br; e.tgt = tgt; e.ill = ill; e.to = to;
    return e;
  endfunction
  function automatic logic any_out();
    return |{alu_a, alu_b, alu_ctrl, alu_sub, alu_sign, alu_is_arch, alu_in_valid, wb_valid,
             wb_result, wb_rd, wb_we, br_taken, br_target, illegal, timeout_err};
  endfunction
  task automatic run(input logic [31:0] i, p, r1, r2, im, input int delay,
                     input logic [31:0] res, input logic brv, input logic [3:0] ctrl,
                     input logic [2:0] ssa, input logic [31:0] ea, eb, input exp_t e, input int hold);
    exp_t g;
    int k;
    @(negedge clock);
    chk("inst_ready", inst_ready, 1);
    inst_valid = 1'b1; inst = i; pc = p; rs1_data = r1; rs2_data = r2; imm = im;
    q.push_back(e);
    @(negedge clock);
    inst_valid = 1'b0;
    if (e.ill) begin
      chk("ill_no_launch", alu_in_valid, 0);
      chk("ill_wb_valid", wb_valid, 1);
    end else begin
      chk("launch", alu_in_valid, 1);
      chk("ctrl", alu_ctrl, ctrl);
      chk("sub_sign_arch", {alu_sub, alu_sign, alu_is_arch}, ssa);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      k = 0;
      forever begin
        @(negedge clock);
        alu_out_valid = 1'b0;
        if (wb_valid || k > 20) break;
        if (k == 0) chk("launch_once", alu_in_valid, 0);
        if (k == delay) begin
          alu_out_valid = 1'b1; alu_result = res; alu_branch = brv;
        end
        k++;
      end
      chk("latency", k, delay < TO ? delay + 1 : TO);
      chk("ctrl_stable", alu_ctrl, ctrl);
    end
    g = q.pop_front();
    if (!g.to) chk("wb_result", wb_result, g.res);
    chk("wb_rd", wb_rd, g.rd);
    chk("wb_we", wb_we, g.we);
    chk("br_taken", br_taken, g.br);
    chk("br_target", br_target, g.tgt);
    chk("illegal", illegal, g.ill);
    chk("timeout_err", timeout_err, g.to);
    repeat (hold) begin
      @(negedge clock);
      chk("hold_valid", wb_valid, 1);
      chk("hold_flags", {wb_rd, wb_we, timeout_err, illegal}, {g.rd, g.we, g.to, g.ill});
      chk("hold_ready", inst_ready, 0);
    end
    wb_ready = 1'b1;
    @(negedge clock);
    wb_ready = 1'b0;
    chk("rel_ready", inst_ready, 1);
    chk("rel_valid", wb_valid, 0);
    chk("rel_flags", {br_taken, illegal, timeout_err}, 0);
  endtask
  initial begin
    #2;
    chk("rst_inst_ready", inst_ready, 1);
    chk("rst_outs", any_out(), 0);
    @(negedge clock);
    reset = 1'b0;
    // ADDI x5,x1,-1
    run(32'hfff08293, 0, 0, 0, 32'hffffffff, 0, 32'hffffffff, 0, 4'b0000, 3'b000,
        0, 32'hffffffff, mk(32'hffffffff, 5, 1, 0, 32'hffffffff, 0, 0), 0);
    // SUB / SRA / SLT / SLTU x3,x1,x2
    run(32'h402081b3, 0, 10, 3, 0, 0, 7, 0, 4'b0000, 3'b100, 10, 3, mk(7, 3, 1, 0, 0, 0, 0), 0);
    run(32'h4020d1b3, 0, 32'h80000000, 4, 0, 0, 32'hf8000000, 0, 4'b0101, 3'b001,
        32'h80000000, 4, mk(32'hf8000000, 3, 1, 0, 0, 0, 0), 0);
    run(32'h0020a1b3, 0, 1, 2, 0, 0, 1, 0, 4'b0010, 3'b110, 1, 2, mk(1, 3, 1, 0, 0, 0, 0), 0);
    run(32'h0020b1b3, 0, 1, 2, 0, 0, 0, 0, 4'b0011, 3'b100, 1, 2, mk(0, 3, 1, 0, 0, 0, 0), 0);
    // BLTU taken, BGE not taken with wrapping target
    run(32'h0020e063, 32'h80000000, 1, 2, 32'h10, 0, 0, 1, 4'b1110, 3'b100, 1, 2,
        mk(0, 0, 0, 1, 32'h80000010, 0, 0), 0);
    run(32'h0020d063, 32'hfffffff0, 1, 2, 32'h20, 0, 0, 0, 4'b1101, 3'b110, 1, 2,
        mk(0, 0, 0, 0, 32'h10, 0, 0), 0);
    // illegal opcode and illegal OP funct7
    run(32'h0000007f, 0, 0, 0, 0, 0, 0, 0, 4'b0, 3'b0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0), 2);
    run(32'h402091b3, 0, 0, 0, 0, 0, 0, 0, 4'b0, 3'b0, 0, 0, mk(0, 3, 0, 0, 0, 1, 0), 0);
    // silent ALU times out; held for 5 cycles
    run(32'hfff08293, 0, 0, 0, 32'hffffffff, 99, 0, 0, 4'b0000, 3'b000,
        0, 32'hffffffff, mk(0, 5, 0, 0, 32'hffffffff, 0, 1), 5);
    // response on the final watchdog cycle wins
    run(32'hfff08293, 0, 0, 0, 32'hffffffff, TO - 1, 32'hffffffff, 0, 4'b0000, 3'b000,
        0, 32'hffffffff, mk(32'hffffffff, 5, 1, 0, 32'hffffffff, 0, 0), 0);
    // ADD x0 writes nothing; LUI/AUIPC operand selection
    run(32'h00208033, 0, 2, 3, 0, 0, 5, 0, 4'b0000, 3'b000, 2, 3, mk(5, 0, 0, 0, 0, 0, 0), 0);
    run(32'h123453b7, 0, 32'h55, 0, 32'h12345000, 0, 32'h12345000, 0, 4'b0000, 3'b000,
        0, 32'h12345000, mk(32'h12345000, 7, 1, 0, 32'h12345000, 0, 0), 0);
    run(32'h00001397, 32'h400, 32'h55, 0, 32'h1000, 0, 32'h1400, 0, 4'b0000, 3'b000,
        32'h400, 32'h1000, mk(32'h1400, 7, 1, 0, 32'h1400, 0, 0), 0);
    // reset while waiting on the ALU
    @(negedge clock);
    inst_valid = 1'b1; inst = 32'h402081b3; rs1_data = 10; rs2_data = 3;
    @(negedge clock);
    inst_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("wait_rst_outs", any_out(), 0);
    chk("wait_rst_ready", inst_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    chk("post_rst_ready", inst_ready, 1);
    chk("post_rst_valid", wb_valid, 0);
    // stale ALU response in IDLE is ignored
    alu_out_valid = 1'b1; alu_result = 32'hdead;
    @(negedge clock);
    alu_out_valid = 1'b0;
    chk("stale_valid", wb_valid, 0);
    @(negedge clock);
    chk("stale_valid2", wb_valid, 0);
    chk("stale_ready", inst_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Dispatch stage that sits in front of the ALU. It accepts one decoded RV32I integer or branch instruction with its operands and encodes the ALU control word. It runs the ALU's in_valid/out_valid handshake, then presents the result and branch outcome to writeback. A watchdog flags an ALU that never answers.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TIMEOUT, 15, maximum number of WAIT cycles before timeout_err; legal range 1 to 2^TW-1.
TW, 4, width of the watchdog counter.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
inst_valid  in  1  instruction offered
inst_ready  out  1  block can accept an instruction; equals (state==IDLE)
inst  in  32  raw instruction word
pc  in  32  instruction PC
rs1_data  in  32  rs1 value
rs2_data  in  32  rs2 value
imm  in  32  sign-extended immediate; U-type immediate is already shifted left by 12
alu_a  out  32  ALU a_in (rs1/pc/0)
alu_b  out  32  ALU b_in (rs2/imm)
alu_ctrl  out  4  ALU ctrl_in
alu_sub  out  1  ALU sub_in
alu_sign  out  1  ALU sign_in
alu_is_arch  out  1  ALU is_arch_in (SRA/SRAI)
alu_in_valid  out  1  one-cycle ALU launch pulse
alu_out_valid  in  1  ALU result valid
alu_result  in  32  ALU result
alu_branch  in  1  ALU branch condition
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts
wb_result  out  32  captured result
wb_rd  out  5  destination register, inst[11:7]
wb_we  out  1  register write enable
br_taken  out  1  branch resolved taken
br_target  out  32  pc+imm, valid when br_taken
illegal  out  1  unsupported encoding
timeout_err  out  1  ALU did not answer within TIMEOUT cycles

Behaviour:
- Reset (async): state=IDLE; every registered output is 0, including alu_in_valid, wb_valid, wb_*, br_*, illegal, timeout_err and alu_*. The watchdog counter resets to 0. A reset in any state abandons the instruction. An alu_out_valid seen outside WAIT is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On inst_valid && inst_ready, register the decode and operands.
  - Go to ISSUE, or to DONE when the encoding is illegal.
  - The illegal path sets illegal=1, wb_result=0, wb_we=0 and never pulses the ALU.
- ISSUE: alu_in_valid=1 for exactly one cycle. Load watchdog=TIMEOUT. Go to WAIT.
- WAIT:
  - If alu_out_valid: capture wb_result=alu_result and br_taken=alu_branch (branch instructions only), then go to DONE.
  - Otherwise the watchdog decrements. When it reaches 0 without a response: timeout_err=1, wb_we=0, go to DONE.
  - If alu_out_valid and the final decrement fall in the same cycle, alu_out_valid wins.
- DONE: wb_valid=1. All wb_/br_/error outputs are held until wb_ready. On wb_ready go to IDLE, clearing wb_valid, br_taken, illegal and timeout_err.
- alu_* outputs are registered at accept and stay stable from ISSUE until the next accept.
- Latency with a 1-cycle ALU:
  - Accept at edge 0.
  - alu_in_valid in cycle 1.
  - alu_out_valid in cycle 2.
  - wb_valid from cycle 3.
- Throughput: one instruction per 4 cycles minimum.
- Decode, using f3=inst[14:12] and f7=inst[31:25]:
  - OP-IMM (0010011): ctrl={0,f3}, a=rs1, b=imm. sub=1 only for f3=010/011; sign=1 only for f3=010. For f3=001, f7 must be 0. For f3=101, f7 must be 0 or 0x20; is_arch=inst[30].
  - OP (0110011): ctrl={0,f3}, a=rs1, b=rs2. f7 must be 0 or 0x20; 0x20 is legal only with f3=000 (SUB, sub=1) or f3=101 (SRA, is_arch=1). SLT/SLTU: sub=1, sign as for OP-IMM.
  - LUI (0110111): a=0, b=imm, ctrl=0000.
  - AUIPC (0010111): a=pc, b=imm, ctrl=0000.
  - BRANCH (1100011): ctrl={1,f3}, a=rs1, b=rs2, sub=1, sign=f3[2]&~f3[1]. f3=010/011 is illegal. wb_we=0; br_target=pc+imm (own adder, wraps mod 2^32).
  - Any other opcode is illegal.
- wb_we=1 iff a legal non-branch instruction completes without timeout and wb_rd!=0.

Test Plan:
- ADDI x5,x1,-1 with rs1=0, imm=0xFFFFFFFF: ctrl=0000, sub=0; alu_in_valid in cycle 1 only; with ALU model answering 0xFFFFFFFF, wb_valid in cycle 3, wb_result=0xFFFFFFFF, wb_rd=5, wb_we=1.
- SUB/SRA/SLT encodings: SUB gives ctrl=0000, sub=1. SRA gives ctrl=0101, is_arch=1, sub=0. SLT gives ctrl=0010, sub=1, sign=1. SLTU gives sign=0.
- BLTU with pc=0x80000000, imm=0x10: ctrl=1110, sub=1, sign=0; ALU branch=1 -> br_taken=1, br_target=0x80000010, wb_we=0. BGE gives ctrl=1101, sign=1.
- Illegal inst 0x0000007F accepted -> no alu_in_valid; illegal=1 and wb_valid one cycle after accept; wb_we=0.
- ALU silent with TIMEOUT=3 -> timeout_err=1 and wb_valid after 3 WAIT cycles. Hold wb_ready=0 for 5 cycles: outputs stable. wb_ready=1 -> IDLE, inst_ready=1.
- Assert reset during WAIT -> all outputs 0 immediately and inst_ready=1 after release. A stale alu_out_valid in IDLE -> no wb_valid. Writing rd=x0 completes with wb_we=0.
